// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the fetch datapath: PC update selects and instruction field positions.
package fetch_unit_pkg;

   localparam int unsigned INSTR_W = 16;

   typedef enum logic [1:0] {
      PC_HOLD   = 2'b00,
      PC_INC    = 2'b01,
      PC_BRANCH = 2'b10,
      PC_CLEAR  = 2'b11
   } pc_ctrl_e;

   localparam int unsigned OPCODE_MSB = 15;
   localparam int unsigned OPCODE_LSB = 12;
   localparam int unsigned RD_MSB     = 11;
   localparam int unsigned RD_LSB     = 10;
   localparam int unsigned RS_MSB     = 9;
   localparam int unsigned RS_LSB     = 8;
   localparam int unsigned RT_MSB     = 7;
   localparam int unsigned RT_LSB     = 6;
   localparam int unsigned IMM_MSB    = 7;
   localparam int unsigned IMM_LSB    = 0;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read port between the fetch unit (master) and the memory (slave).
interface fetch_unit_if #(
   parameter int unsigned PC_W = 8
);
   logic                mem_req;
   logic [PC_W-1:0]     mem_addr;
   logic                mem_ready;
   logic [15:0]         mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ready,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ready,
      output mem_rdata
   );
endinterface

// File: rtl/fetch_unit_pc_unit.sv
// Program counter register with hold/increment/relative-branch/clear update, modulo 2^PC_W.
module pc_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned PC_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en_pc_i,
   input  logic [1:0]      pc_ctrl_i,
   input  logic [7:0]      imm_i,
   output logic [PC_W-1:0] pc_o
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic [PC_W-1:0] imm_ext;

   // Narrow PCs take the low bits of the offset; wide PCs sign-extend it.
   generate
      if (PC_W > 8) begin : g_sext
         assign imm_ext = {{(PC_W-8){imm_i[7]}}, imm_i};
      end else begin : g_trunc
         assign imm_ext = imm_i[PC_W-1:0];
      end
   endgenerate

   always_comb begin
      pc_d = pc_q;
      if (en_pc_i) begin
         case (pc_ctrl_e'(pc_ctrl_i))
            PC_INC:    pc_d = pc_q + PC_W'(1);
            PC_BRANCH: pc_d = pc_q + imm_ext;
            PC_CLEAR:  pc_d = '0;
            default:   pc_d = pc_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM and instruction register; answers the control FSM with a one-cycle fetch_done.
// Optional macro FETCH_TIMEOUT_EN adds a bounded mem_ready wait and a sticky fetch_err flag.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned PC_W    = 8,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en_fetch_pulse,
   input  logic               en_pc_pulse,
   input  logic [1:0]         pc_ctrl,
   fetch_unit_if.master       mem_if,
   output logic               fetch_done,
   output logic               busy,
   output logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] ir,
   output logic [3:0]         opcode,
   output logic [1:0]         rd,
   output logic [1:0]         rs,
   output logic [1:0]         rt,
   output logic [7:0]         imm,
   output logic               fetch_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DONE
   } state_e;

   state_e               state_q;
   state_e               state_d;
   logic [PC_W-1:0]      mem_addr_q;
   logic [INSTR_W-1:0]   ir_q;
   logic                 accept;
   logic                 timeout_hit;

   generate
      if (TIMEOUT < 1) begin : g_bad_timeout
         $error("fetch_unit: TIMEOUT must be at least 1");
      end
   endgenerate

   assign accept = (state_q == S_IDLE) && en_fetch_pulse;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (en_fetch_pulse) state_d = S_REQ;
         S_REQ:  if (mem_if.mem_ready || timeout_hit) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_if.mem_req = (state_q == S_REQ);
      fetch_done     = (state_q == S_DONE);
      busy           = (state_q != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_addr_q <= '0;
         ir_q       <= '0;
      end else begin
         if (accept) begin
            mem_addr_q <= pc;
         end
         if ((state_q == S_REQ) && mem_if.mem_ready) begin
            ir_q <= mem_if.mem_rdata;
         end else if (timeout_hit) begin
            ir_q <= '0;
         end
      end
   end

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

   logic [WAIT_W-1:0] wait_q;
   logic [WAIT_W-1:0] wait_d;
   logic              err_q;
   logic              err_d;

   // The TIMEOUT-th idle REQ cycle fires the timeout, so DONE follows exactly TIMEOUT wait cycles.
   always_comb begin
      wait_d      = wait_q;
      err_d       = err_q;
      timeout_hit = 1'b0;
      if (accept) begin
         wait_d = '0;
      end else if ((state_q == S_REQ) && !mem_if.mem_ready) begin
         wait_d = wait_q + WAIT_W'(1);
         if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
            timeout_hit = 1'b1;
            err_d       = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wait_q <= wait_d;
         err_q  <= err_d;
      end
   end

   assign fetch_err = err_q;
`else
   assign timeout_hit = 1'b0;
   assign fetch_err   = 1'b0;
`endif

   pc_unit #(
      .PC_W (PC_W)
   ) u_pc_unit (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_pc_i   (en_pc_pulse),
      .pc_ctrl_i (pc_ctrl),
      .imm_i     (ir_q[IMM_MSB:IMM_LSB]),
      .pc_o      (pc)
   );

   assign mem_if.mem_addr = mem_addr_q;
   assign ir              = ir_q;
   assign opcode          = ir_q[OPCODE_MSB:OPCODE_LSB];
   assign rd              = ir_q[RD_MSB:RD_LSB];
   assign rs              = ir_q[RS_MSB:RS_LSB];
   assign rt              = ir_q[RT_MSB:RT_LSB];
   assign imm             = ir_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_fetch_unit;

   localparam int unsigned PC_W = 8;
   localparam int unsigned TMO  = 15;
   localparam int          MASK = (1 << PC_W) - 1;

   logic            clk      = 1'b0;
   logic            rst_n    = 1'b0;
   logic            en_fetch = 1'b0;
   logic            en_pc    = 1'b0;
   logic [1:0]      pc_ctrl  = 2'b00;
   logic            fetch_done, busy, fetch_err;
   logic [PC_W-1:0] pc;
   logic [15:0]     ir;
   logic [3:0]      opcode;
   logic [1:0]      rd, rs, rt;
   logic [7:0]      imm;

   fetch_unit_if #(.PC_W(PC_W)) bus ();

   fetch_unit #(
      .PC_W    (PC_W),
      .TIMEOUT (TMO)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en_fetch_pulse (en_fetch),
      .en_pc_pulse    (en_pc),
      .pc_ctrl        (pc_ctrl),
      .mem_if         (bus),
      .fetch_done     (fetch_done),
      .busy           (busy),
      .pc             (pc),
      .ir             (ir),
      .opcode         (opcode),
      .rd             (rd),
      .rs             (rs),
      .rt             (rt),
      .imm            (imm),
      .fetch_err      (fetch_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      else n_pass++;
   endfunction

   // Behavioural model: a fetch is either outstanding (waiting for data) or just completed.
   int  m_pc = 0, m_addr = 0, m_ir = 0, m_wait = 0;
   bit  m_req = 0, m_done = 0, m_err = 0;
   int  nxt_pc, br;
   bit  was_done;
   logic [7:0] lo;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_pc = 0; m_addr = 0; m_ir = 0; m_wait = 0;
         m_req = 0; m_done = 0; m_err = 0;
      end else begin
         lo = m_ir[7:0];
         br = $signed(lo);
         nxt_pc = m_pc;
         if (en_pc) begin
            case (pc_ctrl)
               2'd1: nxt_pc = (m_pc + 1) & MASK;
               2'd2: nxt_pc = (m_pc + br) & MASK;
               2'd3: nxt_pc = 0;
               default: nxt_pc = m_pc;
            endcase
         end
         was_done = m_done;
         m_done = 0;
         if (m_req) begin
            if (bus.mem_ready) begin
               m_ir = bus.mem_rdata; m_req = 0; m_done = 1;
            end
`ifdef FETCH_TIMEOUT_EN
            else begin
               m_wait++;
               if (m_wait == TMO) begin
                  m_ir = 0; m_err = 1; m_req = 0; m_done = 1;
               end
            end
`endif
         end else if (!was_done && en_fetch) begin
            m_req = 1; m_addr = m_pc; m_wait = 0;
         end
         m_pc = nxt_pc;
      end
   end

   always @(negedge clk) begin
      chk("pc",         pc,            m_pc);
      chk("ir",         ir,            m_ir);
      chk("mem_req",    bus.mem_req,   m_req);
      chk("mem_addr",   bus.mem_addr,  m_addr);
      chk("fetch_done", fetch_done,    m_done);
      chk("busy",       busy,          m_req | m_done);
      chk("opcode",     opcode,        (m_ir >> 12) & 15);
      chk("rd",         rd,            (m_ir >> 10) & 3);
      chk("rs",         rs,            (m_ir >> 8) & 3);
      chk("rt",         rt,            (m_ir >> 6) & 3);
      chk("imm",        imm,           m_ir & 255);
      chk("fetch_err",  fetch_err,     m_err);
   end

   task automatic drive(bit f, bit p, logic [1:0] c, bit r, logic [15:0] d);
      en_fetch = f; en_pc = p; pc_ctrl = c; bus.mem_ready = r; bus.mem_rdata = d;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic fetch_now(logic [15:0] d);
      drive(1, 0, 2'd0, 0, 16'h0); tick();
      drive(0, 0, 2'd0, 1, d);     tick();
      drive(0, 0, 2'd0, 0, 16'h0); tick();
   endtask

   int n_done;
   int c;

   initial begin
      drive(0, 0, 2'd0, 0, 16'h0);
      rst_n = 1'b0;
      tick(); tick();
      chk("rst_pc", pc, 0);
      chk("rst_ir", ir, 0);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fetch_err", fetch_err, 0);

      // First fetch at pc 0, data ready in cycle 1
      rst_n = 1'b1;
      drive(1, 0, 2'd0, 0, 16'h0); tick();
      chk("t1_req", bus.mem_req, 1);
      chk("t1_addr", bus.mem_addr, 0);
      drive(0, 0, 2'd0, 1, 16'h1234); tick();
      chk("t1_done", fetch_done, 1);
      chk("t1_ir", ir, 16'h1234);
      chk("t1_opcode", opcode, 1);
      chk("t1_rd", rd, 0);
      chk("t1_req_off", bus.mem_req, 0);
      drive(0, 0, 2'd0, 0, 16'h0); tick();
      chk("t1_done_off", fetch_done, 0);

      // Simultaneous fetch and increment at pc 5, ready in cycle 4
      repeat (5) begin drive(0, 1, 2'd1, 0, 16'h0); tick(); end
      chk("t2_pc5", pc, 5);
      drive(1, 1, 2'd1, 0, 16'h0); tick();
      chk("t2_addr", bus.mem_addr, 5);
      chk("t2_pc6", pc, 6);
      drive(0, 0, 2'd0, 0, 16'h0);
      for (int k = 2; k <= 4; k++) begin
         tick();
         chk("t2_no_done", fetch_done, 0);
         chk("t2_addr_stable", bus.mem_addr, 5);
      end
      drive(0, 0, 2'd0, 1, 16'h7C01); tick();
      chk("t2_done", fetch_done, 1);
      chk("t2_ir", ir, 16'h7C01);
      drive(0, 0, 2'd0, 0, 16'h0); tick();

      // PC wrap and negative branch
      fetch_now(16'h00FF);
      drive(0, 1, 2'd3, 0, 16'h0); tick();
      chk("t3_clear", pc, 0);
      drive(0, 1, 2'd2, 0, 16'h0); tick();
      chk("t3_br_ff", pc, 8'hFF);
      drive(0, 1, 2'd1, 0, 16'h0); tick();
      chk("t3_wrap", pc, 0);
      repeat (3) begin drive(0, 1, 2'd1, 0, 16'h0); tick(); end
      drive(0, 0, 2'd0, 0, 16'h0); tick();
      fetch_now(16'h00FE);
      chk("t3_pc3", pc, 3);
      drive(0, 1, 2'd2, 0, 16'h0); tick();
      chk("t3_br_back", pc, 1);

      // Extra fetch pulses in REQ and DONE are ignored
      n_done = 0;
      drive(1, 0, 2'd0, 0, 16'h0); tick(); n_done += fetch_done;
      drive(1, 0, 2'd0, 0, 16'h0); tick(); n_done += fetch_done;
      drive(0, 0, 2'd0, 0, 16'h0); tick(); n_done += fetch_done;
      drive(0, 0, 2'd0, 1, 16'h5A5A); tick(); n_done += fetch_done;
      drive(1, 0, 2'd0, 0, 16'h0); tick(); n_done += fetch_done;
      chk("t4_done_ignored", bus.mem_req, 0);
      drive(0, 0, 2'd0, 1, 16'h0);
      repeat (4) begin tick(); n_done += fetch_done; end
      chk("t4_one_done", n_done, 1);

      // Reset in REQ abandons the fetch
      drive(0, 1, 2'd1, 0, 16'h0); tick();
      drive(1, 0, 2'd0, 0, 16'h0); tick();
      chk("t5_in_req", bus.mem_req, 1);
      rst_n = 1'b0;
      drive(0, 0, 2'd0, 1, 16'hBEEF); tick();
      chk("t5_req_off", bus.mem_req, 0);
      chk("t5_pc", pc, 0);
      rst_n = 1'b1;
      n_done = fetch_done;
      repeat (3) begin tick(); n_done += fetch_done; end
      chk("t5_no_done", n_done, 0);
      chk("t5_ir", ir, 0);

`ifdef FETCH_TIMEOUT_EN
      drive(1, 0, 2'd0, 0, 16'h0); tick();
      c = 1;
      drive(0, 0, 2'd0, 0, 16'h0);
      while (!fetch_done && c < 40) begin tick(); c++; end
      chk("t6_tmo_cycle", c, TMO + 1);
      chk("t6_ir", ir, 0);
      chk("t6_err", fetch_err, 1);
      tick();
      fetch_now(16'hC3C3);
      chk("t6_err_sticky", fetch_err, 1);
`else
      drive(1, 0, 2'd0, 0, 16'h0); tick();
      n_done = 0;
      drive(0, 0, 2'd0, 0, 16'h0);
      repeat (20) begin tick(); n_done += fetch_done; end
      chk("t6_wait_forever", n_done, 0);
      chk("t6_still_req", bus.mem_req, 1);
      drive(0, 0, 2'd0, 1, 16'h3C3C); tick();
      chk("t6_late_done", fetch_done, 1);
      chk("t6_no_err", fetch_err, 0);
      drive(0, 0, 2'd0, 0, 16'h0); tick();
`endif

      // Randomized run, checked every cycle against the model
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         drive(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
               2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 4),
               16'($urandom()));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and program-counter datapath that answers the processor control state machine. It consumes the control FSM's `en_fetch_pulse`, `en_pc_pulse` and `pc_ctrl` and returns the single-cycle `fetch_done` (wired to the control FSM's `en1`) once a fetched instruction is stable. While `fetch_done` is high, it presents the decoded `opcode` and `rd` fields that the control FSM samples. It sits between the control FSM and the instruction memory port.

## Interface
- `PC_W`, 8: PC and memory address width in bits; PC is word-addressed.
- `TIMEOUT`, 15: maximum `mem_ready` wait in cycles. Used only when `FETCH_TIMEOUT_EN` is defined.

- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst_n`  in  1  Reset, synchronous, active-low.
- `en_fetch_pulse`  in  1  One-cycle request to fetch at the current PC.
- `en_pc_pulse`  in  1  One-cycle request to update the PC according to `pc_ctrl`.
- `pc_ctrl`  in  2  PC update select: 00 hold, 01 increment, 10 relative branch, 11 clear.
- `mem_req`  out  1  Instruction memory read request (level).
- `mem_addr`  out  PC_W  Registered read address.
- `mem_ready`  in  1  Read data valid. Sampled only while `mem_req`=1.
- `mem_rdata`  in  16  Instruction word.
- `fetch_done`  out  1  One-cycle pulse: IR updated. Drives the control FSM's `en1`.
- `busy`  out  1  High from the cycle after an accepted fetch through the `fetch_done` cycle.
- `pc`  out  PC_W  Program counter.
- `ir`  out  16  Instruction register.
- `opcode`  out  4  ir[15:12], combinational.
- `rd`  out  2  ir[11:10], combinational.
- `rs`  out  2  ir[9:8], combinational.
- `rt`  out  2  ir[7:6], combinational.
- `imm`  out  8  ir[7:0], combinational.
- `fetch_err`  out  1  Sticky timeout flag. Constant 0 when `FETCH_TIMEOUT_EN` is undefined.

## Operation
- Reset (`rst_n`=0 at a clock edge) clears all state and outputs: `pc`, `ir`, `mem_addr`, `mem_req`, `fetch_done`, `busy`, `fetch_err` = 0, FSM = IDLE. Reset mid-fetch abandons the fetch; no `fetch_done` is produced.
- Fetch FSM:
  - IDLE: on `en_fetch_pulse`, latch `mem_addr` <= `pc`, go to REQ.
  - REQ: `mem_req`=1. On `mem_ready`, latch `ir` <= `mem_rdata`, go to DONE.
  - DONE: `fetch_done`=1, go to IDLE.
- `en_fetch_pulse` arriving in REQ or DONE is ignored. There is no queueing.
- PC update on `en_pc_pulse`:
  - 01: `pc` + 1.
  - 10: `pc` + sign-extended `imm` of the current `ir` (8 bits extended to PC_W; truncated to the low PC_W bits if PC_W < 8).
  - 11: 0.
  - 00: hold.
- All PC arithmetic is modulo 2^PC_W; e.g. 8'hFF + 1 -> 8'h00.
- PC updates are independent of FSM state. They are accepted in any state, including during a fetch.
- When `en_fetch_pulse` and `en_pc_pulse` are high in the same cycle, the fetch address is the pre-update PC, and the PC advances at the same edge.

## Timing
- Fetch request at cycle 0 (`en_fetch_pulse`=1): `mem_req`=1 from cycle 1.
- `mem_ready` at cycle N≥1: `ir` is valid from cycle N+1, and `fetch_done`=1 in cycle N+1 only.
- Minimum latency from `en_fetch_pulse` to `fetch_done` is 2 cycles.
- `mem_req` deasserts in cycle N+1.
- `mem_addr` is stable for the entire REQ state.
- `opcode` and `rd` are valid when `fetch_done` is high and stay stable until the next `fetch_done`.
- The PC update is visible on `pc` one cycle after `en_pc_pulse`.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A wait counter increments each REQ cycle with `mem_ready`=0.
  - After TIMEOUT such cycles, the block loads `ir` <= 16'h0000, sets `fetch_err`, and goes to DONE, so `fetch_done` still pulses.
  - The counter clears when a fetch is accepted.
  - `fetch_err` clears only on reset.
- `FETCH_TIMEOUT_EN` undefined: no counter; REQ waits indefinitely; `fetch_err` is tied to 0.

## Structure
- Shared header `pc_ctrl.vh` holds the `PC_HOLD`/`PC_INC`/`PC_BRANCH`/`PC_CLEAR` encodings, alongside the existing opcode header, and the instruction field bit positions.
- The FSM state localparams stay inside this module.
- One sub-module, `pc_unit`: the PC register, `pc_ctrl` decode and branch adder.

## Test plan
- Reset, then fetch with `pc`=0 and memory returning 16'h1234 with `mem_ready` at cycle 1 -> `mem_addr`=0; `fetch_done` in cycle 2; `ir`=16'h1234, `opcode`=1, `rd`=0.
- Simultaneous fetch and `pc_ctrl`=01 at `pc`=5, with `mem_ready` delayed 4 cycles -> `mem_addr`=5; `pc`=6 next cycle; `fetch_done` in cycle 5.
- `pc`=8'hFF with `pc_ctrl`=01 -> `pc`=0. With `ir`[7:0]=8'hFE and `pc_ctrl`=10 at `pc`=3 -> `pc`=1.
- Second `en_fetch_pulse` issued during REQ -> ignored; exactly one `fetch_done` is produced.
- Reset asserted in REQ -> `mem_req`=0 and `pc`=0 the next cycle; no `fetch_done` is produced.
- With `FETCH_TIMEOUT_EN` and TIMEOUT=15, `mem_ready` held at 0 -> `fetch_done` after 15 wait cycles, `ir`=0, `fetch_err`=1, and `fetch_err` stays 1 across later fetches.
